// File: rtl/frame_dispatcher_pkg.sv
// frame_dispatcher_pkg
// Shared types and constants for the frame dispatcher: FSM state encoding,
// task block granularity, header size, end-of-program marker fill bit and
// the frames-per-beat derivation used to size the core bus.
package frame_dispatcher_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HDR,
      ST_WAIT,
      ST_SEND,
      ST_DONE
   } state_e;

   // Task lengths are counted in blocks of this many frames.
   localparam int unsigned BLOCK_FRAMES = 16;
   // Header occupies the first frames of a task: length, target mask, wait mask.
   localparam int unsigned HDR_FRAMES   = 3;
   // A length word with every bit at this value terminates the program.
   localparam logic        END_MARKER   = 1'b1;

   function automatic int unsigned frames_per_beat(input int unsigned bus_w,
                                                   input int unsigned frame_w);
      return bus_w / frame_w;
   endfunction

endpackage

// File: rtl/frame_dispatcher_mem.sv
// frame_dispatcher_mem
// Program store: DATA_DEPTH x FRAME_SIZE flop array, not reset.
// Ports:
//   clk                 clock
//   wr_en/wr_addr/wr_data  single frame write port
//   hdr_addr/hdr_data   HDR_FRAMES consecutive frames, combinational read
//   beat_addr/beat_data FPB consecutive frames, combinational read
// Read frames are packed lowest address in the LSBs. Addresses past the end
// of the store read as zero.
module frame_dispatcher_mem
   import frame_dispatcher_pkg::*;
#(
   parameter int unsigned DATA_DEPTH = 1024,
   parameter int unsigned FRAME_SIZE = 16,
   parameter int unsigned FPB        = 2,
   localparam int unsigned AW        = $clog2(DATA_DEPTH),
   localparam int unsigned PW        = AW + 1
) (
   input  logic                             clk,
   input  logic                             wr_en,
   input  logic [AW-1:0]                    wr_addr,
   input  logic [FRAME_SIZE-1:0]            wr_data,
   input  logic [PW-1:0]                    hdr_addr,
   output logic [HDR_FRAMES*FRAME_SIZE-1:0] hdr_data,
   input  logic [PW-1:0]                    beat_addr,
   output logic [FPB*FRAME_SIZE-1:0]        beat_data
);

   logic [FRAME_SIZE-1:0] mem_q [DATA_DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_addr] <= wr_data;
      end
   end

   always_comb begin
      hdr_data = '0;
      for (int i = 0; i < int'(HDR_FRAMES); i++) begin
         if ((hdr_addr + PW'(i)) < PW'(DATA_DEPTH)) begin
            hdr_data[i*FRAME_SIZE +: FRAME_SIZE] = mem_q[AW'(hdr_addr + PW'(i))];
         end
      end
   end

   always_comb begin
      beat_data = '0;
      for (int i = 0; i < int'(FPB); i++) begin
         if ((beat_addr + PW'(i)) < PW'(DATA_DEPTH)) begin
            beat_data[i*FRAME_SIZE +: FRAME_SIZE] = mem_q[AW'(beat_addr + PW'(i))];
         end
      end
   end

endmodule

// File: rtl/frame_dispatcher.sv
// frame_dispatcher
// Walks a program image of fixed-size frames task by task. Each task starts
// with a 3-frame header (length, target mask, wait mask); the dispatcher waits
// for the wait-mask cores to be ready, then streams the whole task (header
// included) to the target cores, FPB frames per bus beat.
// Ports:
//   clk, reset                  clock, async active-high reset
//   prog_loading                load mode; forces the FSM back to IDLE
//   prog_we/prog_addr/prog_wdata program store write (load mode only)
//   core_ready                  per-core ready levels
//   bus_ready                   core array accepts the current beat
//   bus_valid/bus_data          registered beat, lowest address in LSBs
//   bus_core_mask               targets of the task in flight
//   bus_first/bus_last          beat position within the task
//   frame_being_sent            FSM is in SEND
//   sched_done                  program finished
//   hdr_error                   sticky malformed-header flag
//
// state   | meaning
// IDLE    | load mode / pointer reset to frame 0
// HDR     | decode header at pointer, check END and bounds
// WAIT    | hold until every wait-mask core reports ready
// SEND    | stream beats, advance on bus_valid && bus_ready
// DONE    | program finished or aborted on header error
module frame_dispatcher
   import frame_dispatcher_pkg::*;
#(
   parameter int unsigned DATA_DEPTH  = 1024,
   parameter int unsigned FRAME_SIZE  = 16,
   parameter int unsigned CORE_NUM    = 16,
   parameter int unsigned BUS_TO_CORE = 32
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          prog_loading,
   input  logic                          prog_we,
   input  logic [$clog2(DATA_DEPTH)-1:0] prog_addr,
   input  logic [FRAME_SIZE-1:0]         prog_wdata,
   input  logic [CORE_NUM-1:0]           core_ready,
   input  logic                          bus_ready,
   output logic                          bus_valid,
   output logic [BUS_TO_CORE-1:0]        bus_data,
   output logic [CORE_NUM-1:0]           bus_core_mask,
   output logic                          bus_first,
   output logic                          bus_last,
   output logic                          frame_being_sent,
   output logic                          sched_done,
   output logic                          hdr_error
);

   localparam int unsigned AW  = $clog2(DATA_DEPTH);
   localparam int unsigned PW  = AW + 1;
   localparam int unsigned FPB = frames_per_beat(BUS_TO_CORE, FRAME_SIZE);
   // Wide enough for pointer + (L+1)*BLOCK_FRAMES with any L, so an oversize
   // length cannot wrap past the bounds check.
   localparam int unsigned XW  = ((FRAME_SIZE > PW) ? FRAME_SIZE : PW)
                                 + $clog2(BLOCK_FRAMES) + 1;

   state_e                 state_q, state_d;
   logic [PW-1:0]          ptr_q, ptr_d;
   logic [PW-1:0]          beat_ptr_q, beat_ptr_d;
   logic [PW-1:0]          end_ptr_q, end_ptr_d;
   logic [CORE_NUM-1:0]    target_q, target_d;
   logic [CORE_NUM-1:0]    wait_q, wait_d;
   logic                   bus_valid_q, bus_valid_d;
   logic [BUS_TO_CORE-1:0] bus_data_q, bus_data_d;
   logic [CORE_NUM-1:0]    bus_mask_q, bus_mask_d;
   logic                   bus_first_q, bus_first_d;
   logic                   bus_last_q, bus_last_d;
   logic                   hdr_error_q, hdr_error_d;

   logic [HDR_FRAMES*FRAME_SIZE-1:0] hdr_data;
   logic [FPB*FRAME_SIZE-1:0]        beat_data;
   logic [FRAME_SIZE-1:0]            hdr_len;
   logic [CORE_NUM-1:0]              hdr_tgt;
   logic [CORE_NUM-1:0]              hdr_wait;
   logic [XW-1:0]                    task_frames;
   logic [XW-1:0]                    task_end_x;
   logic                             hdr_overflow;
   logic                             beat_is_last;
   logic                             load_beat;

   frame_dispatcher_mem #(
      .DATA_DEPTH (DATA_DEPTH),
      .FRAME_SIZE (FRAME_SIZE),
      .FPB        (FPB)
   ) u_mem (
      .clk       (clk),
      .wr_en     (prog_we && prog_loading),
      .wr_addr   (prog_addr),
      .wr_data   (prog_wdata),
      .hdr_addr  (ptr_q),
      .hdr_data  (hdr_data),
      .beat_addr (beat_ptr_q),
      .beat_data (beat_data)
   );

   assign hdr_len      = hdr_data[0 +: FRAME_SIZE];
   assign hdr_tgt      = hdr_data[FRAME_SIZE +: CORE_NUM];
   assign hdr_wait     = hdr_data[2*FRAME_SIZE +: CORE_NUM];
   assign task_frames  = (XW'(hdr_len) + XW'(1)) * XW'(BLOCK_FRAMES);
   assign task_end_x   = XW'(ptr_q) + task_frames;
   assign hdr_overflow = task_end_x > XW'(DATA_DEPTH);
   // beat_ptr_q addresses the beat about to be loaded into the output register.
   assign beat_is_last = (beat_ptr_q + PW'(FPB)) == end_ptr_q;

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      beat_ptr_d  = beat_ptr_q;
      end_ptr_d   = end_ptr_q;
      target_d    = target_q;
      wait_d      = wait_q;
      bus_valid_d = bus_valid_q;
      bus_data_d  = bus_data_q;
      bus_mask_d  = bus_mask_q;
      bus_first_d = bus_first_q;
      bus_last_d  = bus_last_q;
      hdr_error_d = hdr_error_q;
      load_beat   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            ptr_d       = '0;
            hdr_error_d = 1'b0;
            if (!prog_loading) begin
               state_d = ST_HDR;
            end
         end
         ST_HDR: begin
            if (hdr_len == {FRAME_SIZE{END_MARKER}}) begin
               state_d = ST_DONE;
            end else if ((hdr_tgt == '0) || hdr_overflow) begin
               hdr_error_d = 1'b1;
               state_d     = ST_DONE;
            end else begin
               target_d   = hdr_tgt;
               wait_d     = hdr_wait;
               end_ptr_d  = PW'(task_end_x);
               beat_ptr_d = ptr_q;
               state_d    = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if ((core_ready & wait_q) == wait_q) begin
               load_beat   = 1'b1;
               bus_first_d = 1'b1;
               bus_mask_d  = target_q;
               state_d     = ST_SEND;
            end
         end
         ST_SEND: begin
            if (bus_valid_q && bus_ready) begin
               if (bus_last_q) begin
                  bus_valid_d = 1'b0;
                  bus_data_d  = '0;
                  bus_mask_d  = '0;
                  bus_first_d = 1'b0;
                  bus_last_d  = 1'b0;
                  ptr_d       = end_ptr_q;
                  state_d     = (end_ptr_q == PW'(DATA_DEPTH)) ? ST_DONE : ST_HDR;
               end else begin
                  load_beat   = 1'b1;
                  bus_first_d = 1'b0;
               end
            end
         end
         ST_DONE: begin
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (load_beat) begin
         bus_valid_d = 1'b1;
         bus_data_d  = BUS_TO_CORE'(beat_data);
         bus_last_d  = beat_is_last;
         beat_ptr_d  = beat_ptr_q + PW'(FPB);
      end

      // Load mode wins from any state; a partial task is dropped without bus_last.
      if (prog_loading) begin
         state_d     = ST_IDLE;
         bus_valid_d = 1'b0;
         bus_data_d  = '0;
         bus_mask_d  = '0;
         bus_first_d = 1'b0;
         bus_last_d  = 1'b0;
         hdr_error_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         ptr_q       <= '0;
         beat_ptr_q  <= '0;
         end_ptr_q   <= '0;
         target_q    <= '0;
         wait_q      <= '0;
         bus_valid_q <= 1'b0;
         bus_data_q  <= '0;
         bus_mask_q  <= '0;
         bus_first_q <= 1'b0;
         bus_last_q  <= 1'b0;
         hdr_error_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         beat_ptr_q  <= beat_ptr_d;
         end_ptr_q   <= end_ptr_d;
         target_q    <= target_d;
         wait_q      <= wait_d;
         bus_valid_q <= bus_valid_d;
         bus_data_q  <= bus_data_d;
         bus_mask_q  <= bus_mask_d;
         bus_first_q <= bus_first_d;
         bus_last_q  <= bus_last_d;
         hdr_error_q <= hdr_error_d;
      end
   end

   assign bus_valid        = bus_valid_q;
   assign bus_data         = bus_data_q;
   assign bus_core_mask    = bus_mask_q;
   assign bus_first        = bus_first_q;
   assign bus_last         = bus_last_q;
   assign hdr_error        = hdr_error_q;
   assign frame_being_sent = (state_q == ST_SEND);
   assign sched_done       = (state_q == ST_DONE);

endmodule

// File: tb/tb_frame_dispatcher.sv
// tb_frame_dispatcher
// Directed bench for frame_dispatcher with default parameters (FPB = 2).
// Keeps its own image of the program store to predict beat contents.
module tb_frame_dispatcher;
   timeunit 1ns;
   timeprecision 1ps;

   localparam int DEPTH = 1024;
   localparam int FPB   = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        prog_loading;
   logic        prog_we;
   logic [9:0]  prog_addr;
   logic [15:0] prog_wdata;
   logic [15:0] core_ready;
   logic        bus_ready;
   logic        bus_valid;
   logic [31:0] bus_data;
   logic [15:0] bus_core_mask;
   logic        bus_first;
   logic        bus_last;
   logic        frame_being_sent;
   logic        sched_done;
   logic        hdr_error;

   logic [15:0] img [DEPTH];
   int tests = 0;
   int fails = 0;

   frame_dispatcher #(
      .DATA_DEPTH  (1024),
      .FRAME_SIZE  (16),
      .CORE_NUM    (16),
      .BUS_TO_CORE (32)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .prog_loading     (prog_loading),
      .prog_we          (prog_we),
      .prog_addr        (prog_addr),
      .prog_wdata       (prog_wdata),
      .core_ready       (core_ready),
      .bus_ready        (bus_ready),
      .bus_valid        (bus_valid),
      .bus_data         (bus_data),
      .bus_core_mask    (bus_core_mask),
      .bus_first        (bus_first),
      .bus_last         (bus_last),
      .frame_being_sent (frame_being_sent),
      .sched_done       (sched_done),
      .hdr_error        (hdr_error)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: observed timeout, expected run to finish");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [53:0] all_outs();
      return {bus_valid, bus_data, bus_core_mask, bus_first, bus_last,
              frame_being_sent, sched_done, hdr_error};
   endfunction

   function automatic logic [50:0] bus_vec();
      return {bus_valid, bus_data, bus_core_mask, bus_first, bus_last};
   endfunction

   function automatic logic [31:0] exp_beat(input int a);
      return {img[a+1], img[a]};
   endfunction

   task automatic wr(input int a, input logic [15:0] d);
      prog_addr  = 10'(a);
      prog_wdata = d;
      prog_we    = 1'b1;
      tick();
      prog_we    = 1'b0;
      img[a]     = d;
   endtask

   task automatic set_hdr(input int p, input logic [15:0] w0, input logic [15:0] w1,
                          input logic [15:0] w2);
      wr(p, w0);
      wr(p + 1, w1);
      wr(p + 2, w2);
   endtask

   task automatic restart();
      prog_loading = 1'b1;
      tick();
      prog_loading = 1'b0;
   endtask

   // Waits (bounded) for the first beat, then accepts nbeats beats and checks
   // content, mask, first/last placement and stability under back-pressure.
   task automatic run_task(input string tag, input int p, input int nbeats,
                           input logic [15:0] mask, input bit toggle, output int idle);
      int acc, cyc, a;
      int data_bad, mask_bad, first_bad, last_bad, last_cnt, hold_bad;
      logic stall;
      logic [50:0] held;
      idle = 0; acc = 0; cyc = 0;
      data_bad = 0; mask_bad = 0; first_bad = 0; last_bad = 0; last_cnt = 0; hold_bad = 0;
      stall = 1'b0;
      held = '0;
      while (bus_valid !== 1'b1 && idle < 200) begin
         tick();
         idle++;
      end
      chk({tag, "_start_valid"}, 64'(bus_valid), 64'd1);
      while (acc < nbeats && cyc < 4 * nbeats + 20) begin
         bus_ready = toggle ? cyc[0] : 1'b1;
         if (stall && bus_vec() !== held) hold_bad++;
         if (bus_valid === 1'b1 && bus_ready === 1'b1) begin
            a = p + acc * FPB;
            if (bus_data !== exp_beat(a)) data_bad++;
            if (bus_core_mask !== mask) mask_bad++;
            if (bus_first !== (acc == 0)) first_bad++;
            if (bus_last !== (acc == nbeats - 1)) last_bad++;
            if (bus_last === 1'b1) last_cnt++;
            acc++;
         end
         stall = (bus_valid === 1'b1) && (bus_ready !== 1'b1);
         held  = bus_vec();
         cyc++;
         tick();
      end
      bus_ready = 1'b1;
      chk({tag, "_beats"},     64'(acc),       64'(nbeats));
      chk({tag, "_data_bad"},  64'(data_bad),  64'd0);
      chk({tag, "_mask_bad"},  64'(mask_bad),  64'd0);
      chk({tag, "_first_bad"}, 64'(first_bad), 64'd0);
      chk({tag, "_last_bad"},  64'(last_bad),  64'd0);
      chk({tag, "_last_once"}, 64'(last_cnt),  64'd1);
      if (toggle) chk({tag, "_hold_bad"}, 64'(hold_bad), 64'd0);
   endtask

   initial begin
      int idle;
      int hi_cnt;
      reset        = 1'b1;
      prog_loading = 1'b1;
      prog_we      = 1'b0;
      prog_addr    = '0;
      prog_wdata   = '0;
      core_ready   = 16'hffff;
      bus_ready    = 1'b1;
      tick();
      tick();
      chk("reset_outputs", 64'(all_outs()), 64'd0);
      reset = 1'b0;
      tick();

      for (int i = 0; i < DEPTH; i++) wr(i, 16'h8000 | 16'(i));

      // A: two tasks then END marker, full readiness
      set_hdr(0,  16'h0003, 16'h000f, 16'h000f);
      set_hdr(64, 16'h0003, 16'h00f0, 16'h00f0);
      wr(128, 16'hffff);
      prog_loading = 1'b0;
      tick();
      tick();
      chk("a_latency_valid_low", 64'(bus_valid), 64'd0);
      tick();
      chk("a_latency_valid_high", 64'({bus_valid, bus_first, frame_being_sent}), 64'b111);
      run_task("a_t0", 0, 32, 16'h000f, 1'b0, idle);
      chk("a_t0_idle", 64'(idle), 64'd0);
      chk("a_hdr_gap_valid", 64'(bus_valid), 64'd0);
      run_task("a_t1", 64, 32, 16'h00f0, 1'b0, idle);
      chk("a_t1_idle", 64'(idle), 64'd2);
      chk("a_done_not_yet", 64'(sched_done), 64'd0);
      tick();
      chk("a_done", 64'({sched_done, bus_valid, hdr_error}), 64'b100);

      // write outside load mode must not land in the store
      prog_addr  = 10'd0;
      prog_wdata = 16'hffff;
      prog_we    = 1'b1;
      tick();
      prog_we    = 1'b0;

      // B: wait mask blocks Task1 until core_ready covers it
      restart();
      run_task("b_t0", 0, 32, 16'h000f, 1'b0, idle);
      chk("b_t0_idle", 64'(idle), 64'd3);
      core_ready = 16'hff0f;
      hi_cnt = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (bus_valid !== 1'b0) hi_cnt++;
      end
      chk("b_wait_blocked", 64'(hi_cnt), 64'd0);
      core_ready = 16'hffff;
      tick();
      chk("b_release_first", 64'({bus_valid, bus_first}), 64'b11);
      core_ready = 16'h0000;
      run_task("b_t1", 64, 32, 16'h00f0, 1'b0, idle);
      core_ready = 16'hffff;
      tick();
      chk("b_done", 64'(sched_done), 64'd1);

      // C: bus_ready toggling every other cycle
      restart();
      run_task("c_t0", 0, 32, 16'h000f, 1'b1, idle);
      run_task("c_t1", 64, 32, 16'h00f0, 1'b1, idle);
      tick();
      chk("c_done", 64'(sched_done), 64'd1);

      // D: async reset while waiting on Task1, restart from frame 0
      restart();
      run_task("d_t0", 0, 32, 16'h000f, 1'b0, idle);
      core_ready = 16'h0000;
      tick();
      tick();
      tick();
      #2;
      reset = 1'b1;
      #1;
      chk("d_reset_outputs", 64'(all_outs()), 64'd0);
      core_ready = 16'hffff;
      @(posedge clk);
      #1;
      reset = 1'b0;
      tick();
      tick();
      chk("d_restart_valid_low", 64'(bus_valid), 64'd0);
      tick();
      chk("d_restart_beat", 64'({bus_valid, bus_first, bus_core_mask, bus_data}),
          64'({1'b1, 1'b1, 16'h000f, exp_beat(0)}));

      // E1: header 002f at 256 ends exactly at the store end
      prog_loading = 1'b1;
      tick();
      set_hdr(0,   16'h000f, 16'h000f, 16'h000f);
      set_hdr(256, 16'h002f, 16'h0f00, 16'h0f00);
      prog_loading = 1'b0;
      run_task("e1_t0", 0, 128, 16'h000f, 1'b0, idle);
      run_task("e1_t1", 256, 384, 16'h0f00, 1'b0, idle);
      chk("e1_done_at_end", 64'({sched_done, hdr_error, bus_valid}), 64'b100);

      // E2: same header at 512 overruns the store
      prog_loading = 1'b1;
      tick();
      set_hdr(0,   16'h001f, 16'h000f, 16'h000f);
      set_hdr(512, 16'h002f, 16'h0f00, 16'h0f00);
      prog_loading = 1'b0;
      run_task("e2_t0", 0, 256, 16'h000f, 1'b0, idle);
      hi_cnt = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (bus_valid !== 1'b0) hi_cnt++;
      end
      chk("e2_no_beats", 64'(hi_cnt), 64'd0);
      chk("e2_hdr_error", 64'({hdr_error, sched_done}), 64'b11);

      // F: zero target mask
      prog_loading = 1'b1;
      tick();
      chk("f_idle_clears_error", 64'(hdr_error), 64'd0);
      set_hdr(0, 16'h0003, 16'h0000, 16'h0000);
      prog_loading = 1'b0;
      tick();
      tick();
      chk("f_mask0_error", 64'({hdr_error, sched_done, bus_valid}), 64'b110);
      prog_loading = 1'b1;
      tick();
      chk("f_pulse_clears", 64'({hdr_error, sched_done}), 64'b00);

      // G: load mode asserted mid-SEND at beat 10
      set_hdr(0, 16'h0003, 16'h000f, 16'h000f);
      prog_loading = 1'b0;
      tick();
      tick();
      tick();
      chk("g_first_beat", 64'(bus_data), 64'(exp_beat(0)));
      hi_cnt = 0;
      for (int i = 0; i < 10; i++) begin
         if (bus_last === 1'b1) hi_cnt++;
         tick();
      end
      chk("g_no_early_last", 64'(hi_cnt), 64'd0);
      chk("g_beat10", 64'({bus_valid, bus_data}), 64'({1'b1, exp_beat(20)}));
      prog_loading = 1'b1;
      tick();
      chk("g_abort", 64'({bus_valid, bus_last, frame_being_sent}), 64'b000);
      prog_loading = 1'b0;
      tick();
      tick();
      tick();
      chk("g_restart_p0", 64'({bus_valid, bus_first, bus_data}),
          64'({1'b1, 1'b1, exp_beat(0)}));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/frame_dispatcher.md
# frame_dispatcher

Parametrised successor to the core scheduler. It holds a program image of fixed-size frames and walks it task by task. For each task it decodes a 3-frame header, waits until a required set of cores reports ready, then streams the whole task to a target core mask over a wide valid/ready bus that packs several frames per beat. It sits between the program loader and the core array, and adds end-of-program detection, header error flagging and beat back-pressure.

## Interface
- DATA_DEPTH, 1024, frames in program store
- FRAME_SIZE, 16, bits per frame
- CORE_NUM, 16, cores; must be ≤ FRAME_SIZE
- BUS_TO_CORE, 32, bus beat width; FPB = BUS_TO_CORE/FRAME_SIZE must be 1, 2, 4, 8 or 16
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  asynchronous, active-high
- prog_loading  in  1  high: load mode, dispatcher held/returned to IDLE
- prog_we  in  1  frame write strobe; honoured only while prog_loading=1
- prog_addr  in  $clog2(DATA_DEPTH)  frame write address
- prog_wdata  in  FRAME_SIZE  frame write data
- core_ready  in  CORE_NUM  per-core ready level
- bus_ready  in  1  cores accept current beat
- bus_valid  out  1  beat valid
- bus_data  out  BUS_TO_CORE  FPB frames; lowest address in LSBs
- bus_core_mask  out  CORE_NUM  target cores of current task
- bus_first / bus_last  out  1 each  first/last beat of task
- frame_being_sent  out  1  high in SEND state
- sched_done  out  1  program finished
- hdr_error  out  1  sticky malformed header flag

## Operation
- Task layout at frame pointer P: word0 = L (task length = (L+1)*16 frames, header included); word1 = target mask (low CORE_NUM bits); word2 = wait mask.
- word0 all-ones = END marker.
- States: IDLE, HDR, WAIT, SEND, DONE.
- IDLE: P=0. Leave to HDR when prog_loading=0.
- HDR (1 cycle): read words P..P+2 combinationally, then latch len/target/wait. Next state:
  - END marker → DONE.
  - Target mask 0, or P+(L+1)*16 > DATA_DEPTH → set hdr_error, go to DONE.
  - Otherwise → WAIT.
- WAIT: go to SEND when (core_ready & wait) == wait. Wait mask 0 means dispatch immediately.
- SEND: one beat = frames at beat_ptr..beat_ptr+FPB-1. The beat advances only when bus_valid && bus_ready.
- After the last beat is accepted: P += (L+1)*16. If the new P == DATA_DEPTH → DONE, else → HDR.
- DONE: sched_done=1. Stay until prog_loading=1, then go to IDLE.
- prog_loading=1 in any state → IDLE on the next edge. bus_valid drops immediately; a partial task is abandoned with no bus_last.
- hdr_error clears only on reset or on entry to IDLE.
- Pointer arithmetic is $clog2(DATA_DEPTH)+1 bits wide, so the end-of-store compare cannot wrap.

## Timing
- Reset values: all outputs 0, state IDLE, P=0. Program store is not reset.
- prog_loading falls at edge n → HDR at n+1 → WAIT at n+2.
- Mask satisfied during WAIT cycle k → bus_valid=1 with bus_first=1 from the next edge.
- Sustained bus_ready=1 → one beat per cycle; a task takes (L+1)*16/FPB cycles in SEND.
- bus_valid, bus_data, bus_core_mask, bus_first and bus_last are registered. They must stay stable while bus_valid && !bus_ready.
- core_ready changes after WAIT has exited have no effect on the task in flight.
- A write to the store while prog_loading=0 is ignored.
- Back-to-back tasks: one idle bus cycle (HDR), plus WAIT cycles.

## Structure
- Package frame_dispatcher_pkg: state enum, BLOCK_FRAMES=16, HDR_FRAMES=3, END_MARKER ('1), FPB derivation function.
- Sub-module frame_dispatcher_mem: DATA_DEPTH×FRAME_SIZE flop array. One write port, a 3-frame header read port and an FPB-frame beat read port, all read combinationally.
- Top holds the FSM, pointers and output registers.

## Test plan
- Defaults, FPB=2. Task0 = {0003,000f,000f}, Task1 at 64 = {0003,00f0,00f0}, END at 128; core_ready=ffff, bus_ready=1 → 32 beats with mask 000f, 1 HDR cycle, 32 beats with mask 00f0, then sched_done=1.
- Same image, core_ready=ff0f during WAIT of Task1 → bus_valid stays 0. Raise core_ready to ffff → first beat on the next edge.
- bus_ready toggled every other cycle → each beat held stable until accepted; total beats still 32 per task; bus_last exactly once per task.
- Header {002f,0f00,0f00} at P=256 with DATA_DEPTH=1024 → 384 beats, then sched_done (P=1024). Same header at P=512 → hdr_error=1, no beats.
- Target mask 0000 → hdr_error=1 and DONE. prog_loading pulsed → hdr_error cleared, restart at P=0.
- prog_loading asserted mid-SEND at beat 10 → bus_valid=0 next cycle, no bus_last. Async reset mid-WAIT → all outputs 0 immediately.
